dmem_ctrl: RTL and testbench

//  Parametrised byte-addressable data memory for the MEM stage; replaces the fixed word-only dmem.

---
 rtl/dmem_ctrl_pkg.sv | 52 +++++
 rtl/dmem_lane_ram.sv | 53 +++++
 rtl/dmem_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for dmem_ctrl: access-size codes, FSM state codes and the
// store lane-steering / alignment helpers used by the top level.
package dmem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // Byte-lane write request presented to the lane RAM.
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } lane_wr_t;

  // Byte accesses are always aligned; the reserved size code behaves as a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~lane[0];
      default:   ok = (lane == 2'b00);
    endcase
    return ok;
  endfunction

  // Store data arrives right-aligned; replicate it so every candidate lane sees
  // the right bits and let the byte enables pick the lanes that change.
  function automatic lane_wr_t steer_store(input logic [1:0]  size,
                                           input logic [1:0]  lane,
                                           input logic [31:0] data);
    lane_wr_t w;
    case (size)
      SIZE_BYTE: begin
        w.be   = 4'b0001 << lane;
        w.data = {4{data[7:0]}};
      end
      SIZE_HALF: begin
        w.be   = lane[1] ? 4'b1100 : 4'b0011;
        w.data = {2{data[15:0]}};
      end
      default: begin
        w.be   = 4'b1111;
        w.data = data;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Word-organised RAM with four byte-lane write enables, one write port and a
// registered read port; DMEM_DEBUG_PORT_EN adds a second registered read port.
module dmem_lane_ram #(
  parameter int NB_DATA  = 32,
  parameter int NB_WADDR = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          we,
  input  logic [NB_WADDR-1:0] waddr,
  input  logic [NB_DATA-1:0]  wdata,
  input  logic                re,
  input  logic [NB_WADDR-1:0] raddr,
  output logic [NB_DATA-1:0]  rdata
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [NB_WADDR-1:0] dbg_addr,
  output logic [NB_DATA-1:0]  dbg_data
`endif
);

  localparam int DEPTH = 2 ** NB_WADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register only advances on an accepted load so the last result holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

`ifdef DMEM_DEBUG_PORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory for the MEM stage with post-reset clear sweep.
// Optional macro DMEM_DEBUG_PORT_EN adds a read-only debug word port.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 9,
  parameter int NB_SIZE = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_mem_enable,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [NB_SIZE-1:0] i_size,
  input  logic               i_unsigned,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_ready,
  output logic               o_misaligned
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR-3:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data
`endif
);

  localparam int NB_WADDR = NB_ADDR - 2;

  logic [0:0]          state;
  logic [NB_WADDR-1:0] clr_cnt;
  logic                clearing;

  logic [1:0]          lane_p0;
  logic [1:0]          size_p0;
  logic [NB_WADDR-1:0] widx_p0;
  logic                req_p0;
  logic                aligned_p0;
  logic                store_p0;
  logic                load_p0;
  logic                bad_p0;
  lane_wr_t            st_p0;

  logic [3:0]          ram_we;
  logic [NB_WADDR-1:0] ram_waddr;
  logic [NB_DATA-1:0]  ram_wdata;
  logic [NB_DATA-1:0]  rdata_p1;

  logic                vld_p1;
  logic                mis_p1;
  logic [1:0]          lane_p1;
  logic [1:0]          size_p1;
  logic                uns_p1;

  // Pick the addressed byte/half from the read word and extend to full width.
  function automatic logic [NB_DATA-1:0] extend_load(input logic [NB_DATA-1:0] word,
                                                     input logic [1:0]         lane,
                                                     input logic [1:0]         size,
                                                     input logic               uns);
    logic [7:0]         b;
    logic [15:0]        h;
    logic [NB_DATA-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{(NB_DATA-8){b[7] & ~uns}}, b};
      SIZE_HALF: r = {{(NB_DATA-16){h[15] & ~uns}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  assign clearing = (state == S_CLEAR);
  assign o_ready  = (state == S_READY);

  // Clear sweep: one word per cycle from word 0, then park in S_READY until reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        state <= S_READY;
      end
    end
  end

  // ---- stage p0: request decode, alignment check, store steering ----
  assign lane_p0    = i_addr[1:0];
  assign size_p0    = i_size[1:0];
  assign widx_p0    = i_addr[NB_ADDR-1:2];
  assign req_p0     = o_ready & i_mem_enable & (i_read | i_write);
  assign aligned_p0 = is_aligned(size_p0, lane_p0);
  assign store_p0   = req_p0 & aligned_p0 & i_write;
  assign load_p0    = req_p0 & aligned_p0 & i_read & ~i_write;
  assign bad_p0     = req_p0 & ~aligned_p0;
  assign st_p0      = steer_store(size_p0, lane_p0, i_data);

  always_comb begin
    ram_we    = 4'b0000;
    ram_waddr = widx_p0;
    ram_wdata = st_p0.data;
    if (clearing) begin
      ram_we    = 4'b1111;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end else if (store_p0) begin
      ram_we = st_p0.be;
    end
  end

  dmem_lane_ram #(
    .NB_DATA  (NB_DATA),
    .NB_WADDR (NB_WADDR)
  ) u_ram (
    .clk      (i_clk),
    .rst      (i_reset),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .re       (load_p0),
    .raddr    (widx_p0),
    .rdata    (rdata_p1)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .dbg_addr (i_dbg_addr),
    .dbg_data (o_dbg_data)
`endif
  );

  // ---- stage p1: registered load context and status pulses ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p1  <= 1'b0;
      mis_p1  <= 1'b0;
      lane_p1 <= 2'b00;
      size_p1 <= SIZE_WORD;
      uns_p1  <= 1'b0;
    end else begin
      vld_p1 <= load_p0;
      mis_p1 <= bad_p0;
      if (load_p0) begin
        lane_p1 <= lane_p0;
        size_p1 <= size_p0;
        uns_p1  <= i_unsigned;
      end
    end
  end

  // Built only from registers that move together on a load, so o_data holds otherwise.
  assign o_data       = extend_load(rdata_p1, lane_p1, size_p1, uns_p1);
  assign o_valid      = vld_p1;
  assign o_misaligned = mis_p1;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-array reference model checked every cycle, plus
// directed loads/stores with literal expected values.
module tb_dmem_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 9;
  localparam int NB_SIZE = 2;
  localparam int DEPTH   = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic        uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [8:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] o_data;
  logic        o_valid, o_ready, o_mis;
`ifdef DMEM_DEBUG_PORT_EN
  logic [6:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [7:0]  mdl_mem [512];
  bit          m_ready;
  int          m_cnt;
  bit          m_valid, m_mis;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  dmem_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_SIZE(NB_SIZE)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_mem_enable (en),
    .i_read       (rd),
    .i_write      (wr),
    .i_size       (size),
    .i_unsigned   (uns),
    .i_addr       (addr),
    .i_data       (wdata),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_misaligned (o_mis)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .i_dbg_addr   (dbg_addr),
    .o_dbg_data   (dbg_data)
`endif
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_data  = '0;
    for (int i = 0; i < 512; i++) mdl_mem[i] = 8'h00;
  endtask

  // One clock edge of the reference: memory as bytes, loads built byte by byte.
  task automatic model_edge();
    int          n;
    int          a;
    logic [31:0] v;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else if (en && (rd || wr)) begin
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      a = int'(addr);
      if (a % n != 0) begin
        m_mis = 1'b1;
      end else if (wr) begin
        for (int i = 0; i < n; i++) mdl_mem[a + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl_mem[a + i]) << (8 * i));
        if (!uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        m_data  = v;
        m_valid = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ready", 32'(o_ready), 32'(m_ready));
        check("valid", 32'(o_valid), 32'(m_valid));
        check("misaligned", 32'(o_mis), 32'(m_mis));
        check("data", o_data, m_data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // Present a request for exactly one accepting edge; returns just after that edge.
  task automatic req(input bit r, input bit w, input logic [1:0] sz, input bit u,
                     input logic [8:0] a, input logic [31:0] d);
    en = 1'b1; rd = r; wr = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk); #2;
    en = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [8:0] a, input logic [31:0] d);
    req(1'b0, 1'b1, sz, 1'b0, a, d);
  endtask

  task automatic load(string name, input logic [1:0] sz, input bit u, input logic [8:0] a,
                      input logic [31:0] exp);
    req(1'b1, 1'b0, sz, u, a, 32'h0);
    check({name, "_valid"}, 32'(o_valid), 32'd1);
    check(name, o_data, exp);
  endtask

  // Count cycles from reset release until o_ready; optionally fire a store early in the sweep.
  task automatic wait_ready(output int cycles, input bit sw_during);
    cycles = 0;
    while (!o_ready && cycles < 400) begin
      if (sw_during && cycles == 0) begin
        en = 1'b1; wr = 1'b1; rd = 1'b0; size = 2'b10; addr = 9'h050; wdata = 32'hDEAD_BEEF;
      end else if (sw_during && cycles == 3) begin
        en = 1'b0; wr = 1'b0;
      end
      @(posedge clk); #2;
      cycles++;
    end
    en = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int cycles;
    @(posedge clk); @(posedge clk); #2;
    chk_en = 1'b1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_mis", 32'(o_mis), 32'd0);
    check("rst_data", o_data, 32'h0);

    rst = 1'b0;
    wait_ready(cycles, 1'b0);
    check("clear_cycles", 32'(cycles), 32'd128);
    load("lw_1fc", 2'b10, 1'b0, 9'h1FC, 32'h0000_0000);

    store(2'b10, 9'h010, 32'h8081_82F3);
    load("lb_10", 2'b00, 1'b0, 9'h010, 32'hFFFF_FFF3);
    load("lbu_13", 2'b00, 1'b1, 9'h013, 32'h0000_0080);
    load("lh_12", 2'b01, 1'b0, 9'h012, 32'hFFFF_8081);
    load("lhu_12", 2'b01, 1'b1, 9'h012, 32'h0000_8081);
    load("lbu_11", 2'b00, 1'b1, 9'h011, 32'h0000_0082);
    load("lw_10", 2'b10, 1'b0, 9'h010, 32'h8081_82F3);
    @(posedge clk); #2;
    check("valid_drops", 32'(o_valid), 32'd0);
    check("data_holds", o_data, 32'h8081_82F3);

    store(2'b10, 9'h020, 32'hAABB_CCDD);
    store(2'b00, 9'h021, 32'h0000_0011);
    store(2'b01, 9'h022, 32'h0000_2233);
    load("lw_20", 2'b10, 1'b0, 9'h020, 32'h2233_11DD);
    load("lh_22", 2'b01, 1'b0, 9'h022, 32'h0000_2233);
    load("lw_20b", 2'b10, 1'b0, 9'h020, 32'h2233_11DD);

    store(2'b10, 9'h030, 32'h5566_7788);
    req(1'b1, 1'b0, 2'b10, 1'b0, 9'h022, 32'h0);
    check("lw_22_mis", 32'(o_mis), 32'd1);
    check("lw_22_novalid", 32'(o_valid), 32'd0);
    check("lw_22_data_held", o_data, 32'h2233_11DD);
    req(1'b0, 1'b1, 2'b01, 1'b0, 9'h031, 32'h0000_9999);
    check("sh_31_mis", 32'(o_mis), 32'd1);
    load("lw_30", 2'b10, 1'b0, 9'h030, 32'h5566_7788);
    check("lw_30_nomis", 32'(o_mis), 32'd0);

    req(1'b1, 1'b1, 2'b10, 1'b0, 9'h040, 32'hCAFE_F00D);
    check("rw_novalid", 32'(o_valid), 32'd0);
    load("lw_40", 2'b10, 1'b0, 9'h040, 32'hCAFE_F00D);
    load("lrsvd_40", 2'b11, 1'b0, 9'h040, 32'hCAFE_F00D);
    req(1'b1, 1'b0, 2'b11, 1'b0, 9'h042, 32'h0);
    check("lrsvd_42_mis", 32'(o_mis), 32'd1);
    req(1'b0, 1'b0, 2'b10, 1'b0, 9'h040, 32'h0);
    check("noop_novalid", 32'(o_valid), 32'd0);

`ifdef DMEM_DEBUG_PORT_EN
    store(2'b10, 9'h040, 32'h1234_5678);
    dbg_addr = 7'h10;
    @(posedge clk); #2;
    check("dbg_word10", dbg_data, 32'h1234_5678);
`endif

    // Reset in the middle of the sweep restarts it from word 0.
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
    end
    check("midsweep_notready", 32'(o_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    wait_ready(cycles, 1'b1);
    check("reclear_cycles", 32'(cycles), 32'd128);
    load("lw_50_lost", 2'b10, 1'b0, 9'h050, 32'h0000_0000);
    load("lw_10_cleared", 2'b10, 1'b0, 9'h010, 32'h0000_0000);
    @(posedge clk); #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
